// File: rtl/axi_lite_sram_slave.sv
`default_nettype none
// ============================================================================
//  Module      : axi_lite_sram_slave
//  Description : AXI4-Lite slave in front of a word-addressed synchronous
//                SRAM array. It serves one transaction at a time and splits
//                the bus between reads and writes round-robin. Each access
//                waits a fixed or LFSR-driven number of cycles. Addresses
//                outside the array return SLVERR.
//  Revision    : 1.0 - initial release
// ============================================================================
module axi_lite_sram_slave #(
    parameter int                ADDR_W    = 32,
    parameter int                DATA_W    = 32,
    parameter int                DEPTH     = 1024,
    parameter logic [ADDR_W-1:0] BASE_ADDR = 32'h8000_0000,
    parameter int                LAT_MODE  = 0,
    parameter int                FIX_LAT   = 0,
    parameter logic [7:0]        LAT_MASK  = 8'h0F,
    parameter logic [7:0]        LFSR_SEED = 8'hA5
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  arvalid_i,
    output logic                  arready_o,
    input  logic [ADDR_W-1:0]     araddr_i,
    output logic                  rvalid_o,
    input  logic                  rready_i,
    output logic [DATA_W-1:0]     rdata_o,
    output logic [1:0]            rresp_o,
    input  logic                  awvalid_i,
    output logic                  awready_o,
    input  logic [ADDR_W-1:0]     awaddr_i,
    input  logic                  wvalid_i,
    output logic                  wready_o,
    input  logic [DATA_W-1:0]     wdata_i,
    input  logic [DATA_W/8-1:0]   wstrb_i,
    output logic                  bvalid_o,
    input  logic                  bready_i,
    output logic [1:0]            bresp_o
);

    localparam int         STRB_W      = DATA_W / 8;
    localparam int         BYTE_SH     = $clog2(STRB_W);
    localparam int         IDX_W       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_WAIT = 3'd1,
        RD_RESP = 3'd2,
        WR_WAIT = 3'd3,
        WR_RESP = 3'd4
    } state_t;

    state_t              state_q,   state_d;
    logic [7:0]          lfsr_q,    lfsr_d;
    logic [7:0]          cnt_q,     cnt_d;
    logic                last_wr_q, last_wr_d;   // 1: most recent grant went to the write side
    logic [ADDR_W-1:0]   addr_q,    addr_d;
    logic [DATA_W-1:0]   wdata_q,   wdata_d;
    logic [STRB_W-1:0]   wstrb_q,   wstrb_d;
    logic [DATA_W-1:0]   rdata_q,   rdata_d;
    logic [1:0]          rresp_q,   rresp_d;
    logic [1:0]          bresp_q,   bresp_d;

    logic [DATA_W-1:0]   mem [DEPTH];

    logic [ADDR_W-1:0]   offset;
    logic [ADDR_W-1:0]   word_idx;
    logic                in_range;
    logic [IDX_W-1:0]    mem_idx;
    logic                rd_req;
    logic                wr_req;
    logic                grant_rd;
    logic                grant_wr;
    logic [7:0]          lat_load;
    logic                mem_we;

    // Address decode of the latched transaction address (low byte bits dropped)
    always_comb begin
        offset   = addr_q - BASE_ADDR;
        word_idx = offset >> BYTE_SH;
        in_range = (addr_q >= BASE_ADDR) && (word_idx < ADDR_W'(DEPTH));
        mem_idx  = word_idx[IDX_W-1:0];
    end

    // Free-running 8-bit Fibonacci LFSR, x^8+x^6+x^5+x^4+1
    always_comb begin
        lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    end

    // Request arbitration, ready generation and next-state logic
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        last_wr_d = last_wr_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;
        bresp_d   = bresp_q;
        mem_we    = 1'b0;
        arready_o = 1'b0;
        awready_o = 1'b0;
        wready_o  = 1'b0;

        rd_req   = arvalid_i;
        wr_req   = awvalid_i & wvalid_i;
        // On contention the side that did not win last time takes the bus
        grant_rd = rd_req & (~wr_req | last_wr_q);
        grant_wr = wr_req & (~rd_req | ~last_wr_q);
        lat_load = (LAT_MODE != 0) ? (lfsr_q & LAT_MASK) : 8'(FIX_LAT);

        case (state_q)
            IDLE: begin
                if (!rst_i) begin
                    arready_o = grant_rd;
                    awready_o = grant_wr;
                    wready_o  = grant_wr;
                    if (grant_rd) begin
                        addr_d    = araddr_i;
                        cnt_d     = lat_load;
                        last_wr_d = 1'b0;
                        state_d   = RD_WAIT;
                    end else if (grant_wr) begin
                        addr_d    = awaddr_i;
                        wdata_d   = wdata_i;
                        wstrb_d   = wstrb_i;
                        cnt_d     = lat_load;
                        last_wr_d = 1'b1;
                        state_d   = WR_WAIT;
                    end
                end
            end
            RD_WAIT: begin
                if (cnt_q != 8'd0) begin
                    cnt_d = cnt_q - 8'd1;
                end else begin
                    rdata_d = in_range ? mem[mem_idx] : '0;
                    rresp_d = in_range ? RESP_OKAY : RESP_SLVERR;
                    state_d = RD_RESP;
                end
            end
            RD_RESP: begin
                if (rready_i) state_d = IDLE;
            end
            WR_WAIT: begin
                if (cnt_q != 8'd0) begin
                    cnt_d = cnt_q - 8'd1;
                end else begin
                    mem_we  = in_range;
                    bresp_d = in_range ? RESP_OKAY : RESP_SLVERR;
                    state_d = WR_RESP;
                end
            end
            WR_RESP: begin
                if (bready_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            lfsr_q    <= LFSR_SEED;
            cnt_q     <= 8'd0;
            last_wr_q <= 1'b1;
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            rdata_q   <= '0;
            rresp_q   <= RESP_OKAY;
            bresp_q   <= RESP_OKAY;
        end else begin
            state_q   <= state_d;
            lfsr_q    <= lfsr_d;
            cnt_q     <= cnt_d;
            last_wr_q <= last_wr_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
            bresp_q   <= bresp_d;
        end
    end

    // Byte-masked array write; contents intentionally survive reset
    always_ff @(posedge clk_i) begin
        if (mem_we && !rst_i) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (wstrb_q[b]) mem[mem_idx][8*b +: 8] <= wdata_q[8*b +: 8];
            end
        end
    end

    assign rvalid_o = (state_q == RD_RESP);
    assign bvalid_o = (state_q == WR_RESP);
    assign rdata_o  = rdata_q;
    assign rresp_o  = rresp_q;
    assign bresp_o  = bresp_q;

    // Only one response channel is ever active, and neither is withdrawn early
    a_one_resp: assert property (@(posedge clk_i) disable iff (rst_i)
        !(rvalid_o && bvalid_o));
    a_r_hold: assert property (@(posedge clk_i) disable iff (rst_i)
        (rvalid_o && !rready_i) |=> rvalid_o);
    a_b_hold: assert property (@(posedge clk_i) disable iff (rst_i)
        (bvalid_o && !bready_i) |=> bvalid_o);

endmodule
`default_nettype wire

// File: tb/tb_axi_lite_sram_slave.sv
`default_nettype none
// ============================================================================
//  Module      : tb_axi_lite_sram_slave
//  Description : Scoreboard bench for axi_lite_sram_slave. Two instances
//                (fixed zero latency, LFSR latency) share one stimulus bus
//                selected by sel; a monitor compares every response with
//                the queued expectation, including its arrival cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_axi_lite_sram_slave;

    localparam int          DEPTH = 64;
    localparam logic [31:0] BASE  = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        sel;
    logic        arvalid, rready, awvalid, wvalid, bready;
    logic [31:0] araddr, awaddr, wdata;
    logic [3:0]  wstrb;

    logic        arready0, rvalid0, awready0, wready0, bvalid0;
    logic [31:0] rdata0;
    logic [1:0]  rresp0, bresp0;
    logic        arready1, rvalid1, awready1, wready1, bvalid1;
    logic [31:0] rdata1;
    logic [1:0]  rresp1, bresp1;

    logic        arready_m, rvalid_m, awready_m, wready_m, bvalid_m;
    logic [31:0] rdata_m;
    logic [1:0]  rresp_m, bresp_m;

    always #5 clk = ~clk;

    assign arready_m = sel ? arready1 : arready0;
    assign rvalid_m  = sel ? rvalid1  : rvalid0;
    assign awready_m = sel ? awready1 : awready0;
    assign wready_m  = sel ? wready1  : wready0;
    assign bvalid_m  = sel ? bvalid1  : bvalid0;
    assign rdata_m   = sel ? rdata1   : rdata0;
    assign rresp_m   = sel ? rresp1   : rresp0;
    assign bresp_m   = sel ? bresp1   : bresp0;

    axi_lite_sram_slave #(
        .ADDR_W(32), .DATA_W(32), .DEPTH(DEPTH), .BASE_ADDR(BASE),
        .LAT_MODE(0), .FIX_LAT(0), .LAT_MASK(8'h0F), .LFSR_SEED(8'hA5)
    ) u_dut_fix (
        .clk_i(clk), .rst_i(rst),
        .arvalid_i(arvalid & ~sel), .arready_o(arready0), .araddr_i(araddr),
        .rvalid_o(rvalid0), .rready_i(rready), .rdata_o(rdata0), .rresp_o(rresp0),
        .awvalid_i(awvalid & ~sel), .awready_o(awready0), .awaddr_i(awaddr),
        .wvalid_i(wvalid & ~sel), .wready_o(wready0), .wdata_i(wdata), .wstrb_i(wstrb),
        .bvalid_o(bvalid0), .bready_i(bready), .bresp_o(bresp0)
    );

    axi_lite_sram_slave #(
        .ADDR_W(32), .DATA_W(32), .DEPTH(DEPTH), .BASE_ADDR(BASE),
        .LAT_MODE(1), .FIX_LAT(0), .LAT_MASK(8'h0F), .LFSR_SEED(8'hA5)
    ) u_dut_rnd (
        .clk_i(clk), .rst_i(rst),
        .arvalid_i(arvalid & sel), .arready_o(arready1), .araddr_i(araddr),
        .rvalid_o(rvalid1), .rready_i(rready), .rdata_o(rdata1), .rresp_o(rresp1),
        .awvalid_i(awvalid & sel), .awready_o(awready1), .awaddr_i(awaddr),
        .wvalid_i(wvalid & sel), .wready_o(wready1), .wdata_i(wdata), .wstrb_i(wstrb),
        .bvalid_o(bvalid1), .bready_i(bready), .bresp_o(bresp1)
    );

    // ------------------------------------------------------------------
    // Counters, cycle clock and reference LFSR
    // ------------------------------------------------------------------
    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc     = 0;
    logic [7:0]  m_lfsr;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (rst) m_lfsr <= 8'hA5;
        else     m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
    end

    typedef struct {
        bit          is_wr;
        logic [31:0] data;
        logic [1:0]  resp;
        int          cyc;
        string       name;
    } exp_t;

    exp_t sb[$];

    function automatic void check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h, required %0h (t=%0t)", nm, act, exp, $time);
        end
    endfunction

    function automatic int lat_now();
        return sel ? int'(m_lfsr & 8'h0F) : 0;
    endfunction

    function automatic void push_exp(input bit is_wr, input logic [31:0] d,
                                     input logic [1:0] r, input string nm);
        exp_t e;
        e.is_wr = is_wr;
        e.data  = d;
        e.resp  = r;
        e.cyc   = cyc + 2 + lat_now();
        e.name  = nm;
        sb.push_back(e);
    endfunction

    // ------------------------------------------------------------------
    // Monitor: pop and compare on the first cycle of each response
    // ------------------------------------------------------------------
    bit   r_seen, b_seen;
    exp_t mon_e;

    always @(negedge clk) begin
        if (rst) begin
            r_seen = 1'b0;
            b_seen = 1'b0;
        end else begin
            if (rvalid_m && !r_seen) begin
                r_seen = 1'b1;
                if (sb.size() == 0) begin
                    check("unexpected_rvalid", rvalid_m, 0);
                end else begin
                    mon_e = sb.pop_front();
                    check({mon_e.name, "_kind"},  bvalid_m, mon_e.is_wr);
                    check({mon_e.name, "_rdata"}, rdata_m,  mon_e.data);
                    check({mon_e.name, "_rresp"}, rresp_m,  mon_e.resp);
                    check({mon_e.name, "_cycle"}, cyc,      mon_e.cyc);
                end
            end
            if (!rvalid_m) r_seen = 1'b0;
            if (bvalid_m && !b_seen) begin
                b_seen = 1'b1;
                if (sb.size() == 0) begin
                    check("unexpected_bvalid", bvalid_m, 0);
                end else begin
                    mon_e = sb.pop_front();
                    check({mon_e.name, "_kind"},  !rvalid_m, mon_e.is_wr);
                    check({mon_e.name, "_bresp"}, bresp_m,   mon_e.resp);
                    check({mon_e.name, "_cycle"}, cyc,       mon_e.cyc);
                end
            end
            if (!bvalid_m) b_seen = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Stimulus tasks (called and returning on a falling edge)
    // ------------------------------------------------------------------
    task automatic do_read(input logic [31:0] a, input logic [31:0] exp_d,
                           input logic [1:0] exp_r, input string nm);
        bit done = 1'b0;
        arvalid = 1'b1;
        araddr  = a;
        for (int n = 0; n < 100 && !done; n++) begin
            #1;
            if (arready_m) begin
                push_exp(1'b0, exp_d, exp_r, nm);
                done = 1'b1;
            end
            @(negedge clk);
        end
        arvalid = 1'b0;
        if (!done) check({nm, "_arready_timeout"}, arready_m, 1);
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                            input logic [1:0] exp_r, input string nm);
        bit done = 1'b0;
        awvalid = 1'b1;
        wvalid  = 1'b1;
        awaddr  = a;
        wdata   = d;
        wstrb   = s;
        for (int n = 0; n < 100 && !done; n++) begin
            #1;
            if (awready_m) begin
                check({nm, "_wready"}, wready_m, 1);
                push_exp(1'b1, 32'h0, exp_r, nm);
                done = 1'b1;
            end
            @(negedge clk);
        end
        awvalid = 1'b0;
        wvalid  = 1'b0;
        if (!done) check({nm, "_awready_timeout"}, awready_m, 1);
    endtask

    task automatic wait_idle();
        bit done = 1'b0;
        for (int n = 0; n < 300 && !done; n++) begin
            @(negedge clk);
            if (sb.size() == 0 && !rvalid_m && !bvalid_m) done = 1'b1;
        end
        if (!done) check("drain_timeout", sb.size(), 0);
        @(negedge clk);
    endtask

    // ------------------------------------------------------------------
    // Main sequence
    // ------------------------------------------------------------------
    initial begin
        int          grants[3];
        int          g;
        int          rd_n;
        bit          seen;
        bit          found;

        rst = 1'b1; sel = 1'b0;
        arvalid = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
        rready = 1'b1; bready = 1'b1;
        araddr = '0; awaddr = '0; wdata = '0; wstrb = '0;

        // Reset values and readies forced low while in reset
        repeat (3) @(negedge clk);
        check("rst_rvalid", rvalid_m, 0);
        check("rst_bvalid", bvalid_m, 0);
        check("rst_rdata",  rdata_m,  0);
        check("rst_rresp",  rresp_m,  0);
        check("rst_bresp",  bresp_m,  0);
        arvalid = 1'b1; awvalid = 1'b1; wvalid = 1'b1;
        #1;
        check("rst_arready", arready_m, 0);
        check("rst_awready", awready_m, 0);
        arvalid = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
        @(negedge clk);
        rst = 1'b0;

        // Basic write/read, partial strobes, empty strobe
        do_write(32'h8000_0010, 32'hDEADBEEF, 4'hF, 2'b00, "t1_wr");
        do_read (32'h8000_0010, 32'hDEADBEEF, 2'b00, "t1_rd");
        do_write(32'h8000_0010, 32'h11223344, 4'b0101, 2'b00, "t2_wr");
        do_read (32'h8000_0010, 32'hDE22BE44, 2'b00, "t2_rd");
        do_write(32'h8000_0010, 32'hFFFFFFFF, 4'b0000, 2'b00, "t2_wr_nostrb");
        do_read (32'h8000_0010, 32'hDE22BE44, 2'b00, "t2_rd_nostrb");
        do_write(32'h8000_0020, 32'h01234567, 4'hF, 2'b00, "t4_pre");

        // Backpressure on R
        wait_idle();
        rready = 1'b0;
        do_read(32'h8000_0010, 32'hDE22BE44, 2'b00, "t3_rd");
        for (int n = 0; n < 20 && !rvalid_m; n++) @(negedge clk);
        check("t3_rvalid_up", rvalid_m, 1);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("t3_rvalid_held", rvalid_m, 1);
            check("t3_rdata_held",  rdata_m,  32'hDE22BE44);
        end
        rready = 1'b1;
        @(negedge clk);
        arvalid = 1'b1;
        araddr  = 32'h8000_0010;
        #1;
        check("t3_rvalid_drop", rvalid_m,  0);
        check("t3_arready",     arready_m, 1);
        do_read(32'h8000_0010, 32'hDE22BE44, 2'b00, "t3_rd2");

        // Out-of-range accesses and aliasing guards
        do_write(32'h8000_0000, 32'h0A0A0A0A, 4'hF, 2'b00, "t5_w0");
        do_write(32'h8000_00FC, 32'hFCFCFCFC, 4'hF, 2'b00, "t5_wlast");
        do_read (32'h7FFF_FFFC, 32'h0, 2'b10, "t5_rd_low");
        do_read (BASE + 4*DEPTH, 32'h0, 2'b10, "t5_rd_high");
        do_write(BASE + 4*DEPTH, 32'h12345678, 4'hF, 2'b10, "t5_wr_high");
        do_write(32'h7FFF_FFFC, 32'h87654321, 4'hF, 2'b10, "t5_wr_low");
        do_read (32'h8000_0000, 32'h0A0A0A0A, 2'b00, "t5_rd_w0");
        do_read (32'h8000_00FF, 32'hFCFCFCFC, 2'b00, "t5_rd_last");

        // Contention from reset: read, write, read
        wait_idle();
        rst = 1'b1;
        arvalid = 1'b1; araddr = 32'h8000_0020;
        awvalid = 1'b1; wvalid = 1'b1; awaddr = 32'h8000_0020;
        wdata = 32'hCAFEF00D; wstrb = 4'hF;
        repeat (2) @(negedge clk);
        #1;
        check("t4_rst_arready", arready_m, 0);
        check("t4_rst_wready",  wready_m,  0);
        @(negedge clk);
        rst = 1'b0;
        g = 0; rd_n = 0;
        for (int k = 0; k < 3; k++) grants[k] = 2;
        for (int n = 0; n < 60 && g < 3; n++) begin
            #1;
            if (arready_m) begin
                push_exp(1'b0, (rd_n == 0) ? 32'h01234567 : 32'hCAFEF00D, 2'b00, "t4_rd");
                rd_n++;
                grants[g] = 0;
                g++;
            end else if (awready_m) begin
                push_exp(1'b1, 32'h0, 2'b00, "t4_wr");
                grants[g] = 1;
                g++;
            end
            if (g < 3) @(negedge clk);
        end
        @(negedge clk);
        arvalid = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
        check("t4_grant0", grants[0], 0);
        check("t4_grant1", grants[1], 1);
        check("t4_grant2", grants[2], 0);

        // AW without W is never granted
        wait_idle();
        awvalid = 1'b1; wvalid = 1'b0; awaddr = 32'h8000_0020;
        seen = 1'b0;
        repeat (6) begin
            #1;
            if (awready_m || wready_m) seen = 1'b1;
            @(negedge clk);
        end
        awvalid = 1'b0;
        check("t4_aw_only", seen, 0);

        // LFSR latency mode
        wait_idle();
        sel = 1'b1;
        @(negedge clk);
        do_write(32'h8000_0040, 32'h55AA55AA, 4'hF, 2'b00, "t6_wr0");
        do_read (32'h8000_0040, 32'h55AA55AA, 2'b00, "t6_rd0");
        do_write(32'h8000_0044, 32'h0BADCAFE, 4'hF, 2'b00, "t6_wr1");
        do_read (32'h8000_0044, 32'h0BADCAFE, 2'b00, "t6_rd1");
        do_read (BASE + 4*DEPTH, 32'h0, 2'b10, "t6_rd_oor");
        do_read (32'h8000_0040, 32'h55AA55AA, 2'b00, "t6_rd2");

        // Reset during WR_WAIT abandons the write
        wait_idle();
        found = 1'b0;
        for (int n = 0; n < 300 && !found; n++) begin
            if ((m_lfsr & 8'h0F) >= 8'd3) found = 1'b1;
            else @(negedge clk);
        end
        awvalid = 1'b1; wvalid = 1'b1; awaddr = 32'h8000_0040;
        wdata = 32'hDEADDEAD; wstrb = 4'hF;
        #1;
        check("t6_rst_awready", awready_m, 1);
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        do_read(32'h8000_0040, 32'h55AA55AA, 2'b00, "t6_rd_after_rst");
        wait_idle();
        check("sb_empty", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Absolute bound on simulation time
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, %0d pending", sb.size());
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/axi_lite_sram_slave.md
Name: axi_lite_sram_slave

Overview:
- Parametrised AXI4-Lite slave fronting an internal synchronous SRAM array.
- Used as the simulation memory model behind the core's instruction and data fetch masters.
- Generalises the single-width random-latency slave with configurable data width, depth, base address and fixed or LFSR latency.
- Adds full valid/ready response holding, round-robin read/write arbitration, and SLVERR on out-of-range addresses.

Parameters:
- ADDR_W, 32, address width of araddr_i/awaddr_i.
- DATA_W, 32, data width; 32 or 64 only.
- DEPTH, 1024, number of DATA_W-bit words in the array.
- BASE_ADDR, 32'h8000_0000, byte address mapped to word 0.
- LAT_MODE, 0, 0 = fixed latency FIX_LAT, 1 = random latency (lfsr & LAT_MASK).
- FIX_LAT, 0, wait cycles in fixed mode (0..255).
- LAT_MASK, 8'h0F, mask applied to the LFSR in random mode.
- LFSR_SEED, 8'hA5, reset value of the LFSR; must be nonzero.

Ports:
- clk_i  in  1  single clock, all logic on rising edge.
- rst_i  in  1  reset, synchronous, active-high.
- arvalid_i  in  1  read address valid.
- arready_o  out  1  read address ready.
- araddr_i  in  ADDR_W  read byte address.
- rvalid_o  out  1  read data valid.
- rready_i  in  1  read data ready.
- rdata_o  out  DATA_W  read data.
- rresp_o  out  2  read response: 00 OKAY, 10 SLVERR.
- awvalid_i  in  1  write address valid.
- awready_o  out  1  write address ready.
- awaddr_i  in  ADDR_W  write byte address.
- wvalid_i  in  1  write data valid.
- wready_o  out  1  write data ready.
- wdata_i  in  DATA_W  write data.
- wstrb_i  in  DATA_W/8  byte strobes.
- bvalid_o  out  1  write response valid.
- bready_i  in  1  write response ready.
- bresp_o  out  2  write response.

Behaviour:
- Reset:
  - state=IDLE, lfsr=LFSR_SEED, last_grant=WRITE (so the first contended cycle grants read), cnt=0.
  - rvalid_o=0, bvalid_o=0, rdata_o=0, rresp_o=00, bresp_o=00.
  - Ready outputs are forced 0 while rst_i is high.
  - Array contents are not reset.
- Reset mid-transaction abandons it: an uncommitted write is dropped, and no response is issued after reset.
- States: IDLE, RD_WAIT, RD_RESP, WR_WAIT, WR_RESP.
- Ready and grant rules in IDLE:
  - rd_req = arvalid_i; wr_req = awvalid_i & wvalid_i. AW and W are accepted only together, in the same cycle.
  - Only one side is granted:
    - If only one side requests, it wins.
    - If both request, the side opposite last_grant wins.
  - arready_o = IDLE & read granted. awready_o = wready_o = IDLE & write granted. All ready outputs are 0 outside IDLE.
- On handshake:
  - Latch the address; for writes also latch wdata and wstrb.
  - Load cnt = LAT_MODE ? (lfsr & LAT_MASK) : FIX_LAT.
  - Update last_grant, then go to RD_WAIT or WR_WAIT.
- RD_WAIT / WR_WAIT:
  - If cnt != 0, decrement.
  - If cnt == 0:
    - Read: capture array data and response into rdata_o/rresp_o, then go to RD_RESP.
    - Write: commit strobed bytes to the array, then go to WR_RESP.
- Latency: handshake in cycle T means rvalid_o or bvalid_o is first high in cycle T+2+L, where L is the loaded cnt.
- RD_RESP / WR_RESP:
  - rvalid_o (or bvalid_o) is held high with data and response stable until rready_i (or bready_i) is sampled high.
  - Valid drops the following cycle, the state returns to IDLE, and a new handshake is possible that same cycle.
- Decode:
  - word = (addr - BASE_ADDR) >> log2(DATA_W/8); low address bits are ignored (no alignment error).
  - If addr < BASE_ADDR or word >= DEPTH: response 10, rdata 0, write suppressed.
  - Otherwise response 00.
- Write strobes: byte k of the word is written only when wstrb[k]=1. wstrb=0 is a legal no-op that still returns OKAY.
- LFSR: 8-bit Fibonacci, taps x^8+x^6+x^5+x^4+1, advances every cycle after reset regardless of traffic.
- Read-after-write to the same address in back-to-back transactions returns the new data, since the commit precedes the B response.
- Assertions:
  - rvalid_o and bvalid_o are never high together.
  - Neither valid output drops without its ready.

Test Plan:
1. Reset, FIX_LAT=0 → write 32'hDEADBEEF, wstrb 4'hF to 0x8000_0010, bready=1 → bvalid in T+2, bresp 00; read the same address → rvalid in T+2, rdata DEADBEEF, rresp 00.
2. Partial strobe: write 32'h11223344 with wstrb 4'b0101 over a DEADBEEF word → readback DE22BE44.
3. Backpressure: rready_i held 0 for 5 cycles after rvalid → rvalid and rdata stable all 5 cycles; one cycle after rready=1, rvalid=0 and arready=1.
4. Contention: arvalid and awvalid&wvalid held continuously from reset → grants alternate read, write, read; a write with awvalid but wvalid=0 is never granted.
5. Out of range: read 0x7FFF_FFFC and BASE+4*DEPTH → rresp 10, rdata 0; a write there gives bresp 10 and the array is unchanged.
6. LAT_MODE=1 with seed A5: measured response latencies match the reference LFSR model masked by 0F; asserting rst_i during WR_WAIT → no bvalid and the target word is unchanged.
